// File: rtl/gray_pkg.sv
// Shared constants for the grayscale packer: default luma weights, xRGB field
// positions and the byte-packing helper.
package gray_pkg;

    localparam int unsigned COEF_R_DEF   = 77;
    localparam int unsigned COEF_G_DEF   = 150;
    localparam int unsigned COEF_B_DEF   = 29;

    localparam int unsigned R_HI = 23;
    localparam int unsigned R_LO = 16;
    localparam int unsigned G_HI = 15;
    localparam int unsigned G_LO = 8;
    localparam int unsigned B_HI = 7;
    localparam int unsigned B_LO = 0;

    localparam int unsigned PIX_PER_WORD = 4;
    localparam logic [1:0]  LAST_BYTE    = 2'(PIX_PER_WORD - 1);

    // Writing byte 0 starts a fresh word, so bytes not yet filled read as zero.
    function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  val);
        logic [31:0] w;
        if (idx == 2'd0) begin
            w = {24'h0, val};
        end else begin
            w = word;
            w[idx*8 +: 8] = val;
        end
        return w;
    endfunction

endpackage

// File: rtl/gray_luma.sv
// Registered weighted sum of one xRGB pixel into 8-bit luma; 1 cycle from en.
// Holds y/y_valid until consumed; never stalls on its own.
module gray_luma
    import gray_pkg::*;
#(
    parameter int unsigned COEF_R = COEF_R_DEF,
    parameter int unsigned COEF_G = COEF_G_DEF,
    parameter int unsigned COEF_B = COEF_B_DEF
) (
    input  logic        bus_clk,
    input  logic        srst,
    input  logic        en,
    input  logic        consume,
    input  logic [31:0] pix,
    output logic [7:0]  y,
    output logic        y_valid
);

    logic [15:0] sum;
    logic [7:0]  y_d, y_q;
    logic        y_valid_d, y_valid_q;
    logic        unused_alpha;

    assign unused_alpha = ^pix[31:24];

    always_comb begin
        // Weights sum to 256, so the 16-bit sum cannot overflow.
        sum = 16'(COEF_R) * {8'h0, pix[R_HI:R_LO]}
            + 16'(COEF_G) * {8'h0, pix[G_HI:G_LO]}
            + 16'(COEF_B) * {8'h0, pix[B_HI:B_LO]};
        y_d       = y_q;
        y_valid_d = y_valid_q;
        if (en) begin
            y_d       = 8'(sum >> 8);
            y_valid_d = 1'b1;
        end else if (consume) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            y_q       <= 8'h0;
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: rtl/gray_pack_stream.sv
// xRGB FIFO -> luma -> four bytes per word FIFO; pop to write is 3 cycles, 1 pixel/clk.
// out_full stalls every stage in place; pops stop once dout, y and word are all held.
module gray_pack_stream
    import gray_pkg::*;
#(
    parameter int unsigned COEF_R = COEF_R_DEF,
    parameter int unsigned COEF_G = COEF_G_DEF,
    parameter int unsigned COEF_B = COEF_B_DEF
) (
    input  logic        bus_clk,
    input  logic        srst,
    input  logic [31:0] in_dout,
    input  logic        in_empty,
    output logic        in_rd_en,
    output logic [31:0] out_din,
    output logic        out_wr_en,
    input  logic        out_full,
    input  logic        flush,
    output logic [31:0] pixel_count
);

    logic        d_valid_d, d_valid_q;
    logic [31:0] word_d, word_q;
    logic [1:0]  byte_cnt_d, byte_cnt_q;
    logic        word_valid_d, word_valid_q;
    logic        flush_pending_d, flush_pending_q;
    logic [31:0] pixel_count_d, pixel_count_q;

    logic [7:0]  y;
    logic        y_valid;
    logic        pk_acc;
    logic        y_adv;

    gray_luma #(
        .COEF_R (COEF_R),
        .COEF_G (COEF_G),
        .COEF_B (COEF_B)
    ) u_luma (
        .bus_clk (bus_clk),
        .srst    (srst),
        .en      (y_adv),
        .consume (pk_acc),
        .pix     (in_dout),
        .y       (y),
        .y_valid (y_valid)
    );

    // Each stage advances when it is empty or its content leaves this cycle.
    always_comb begin
        out_wr_en = word_valid_q && !out_full;
        pk_acc    = y_valid && (!word_valid_q || out_wr_en);
        y_adv     = d_valid_q && (!y_valid || pk_acc);
        in_rd_en  = !in_empty && !flush_pending_q && (!d_valid_q || y_adv);
    end

    always_comb begin
        d_valid_d       = d_valid_q;
        word_d          = word_q;
        byte_cnt_d      = byte_cnt_q;
        word_valid_d    = word_valid_q && !out_wr_en;
        flush_pending_d = flush_pending_q || flush;
        pixel_count_d   = pixel_count_q + 32'(pk_acc);

        if (in_rd_en) begin
            d_valid_d = 1'b1;
        end else if (y_adv) begin
            d_valid_d = 1'b0;
        end

        if (pk_acc) begin
            word_d = pack_byte(word_q, byte_cnt_q, y);
            if (byte_cnt_q == LAST_BYTE) begin
                word_valid_d = 1'b1;
                byte_cnt_d   = 2'd0;
            end else begin
                byte_cnt_d   = byte_cnt_q + 2'd1;
            end
        end

        // Pipeline drained: emit any partial word (upper bytes already zero).
        if (flush_pending_q && !d_valid_q && !y_valid && !word_valid_q) begin
            if (byte_cnt_q != 2'd0) begin
                word_valid_d = 1'b1;
                byte_cnt_d   = 2'd0;
            end
            flush_pending_d = 1'b0;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            d_valid_q       <= 1'b0;
            word_q          <= 32'h0;
            byte_cnt_q      <= 2'd0;
            word_valid_q    <= 1'b0;
            flush_pending_q <= 1'b0;
            pixel_count_q   <= 32'h0;
        end else begin
            d_valid_q       <= d_valid_d;
            word_q          <= word_d;
            byte_cnt_q      <= byte_cnt_d;
            word_valid_q    <= word_valid_d;
            flush_pending_q <= flush_pending_d;
            pixel_count_q   <= pixel_count_d;
        end
    end

    assign out_din     = word_q;
    assign pixel_count = pixel_count_q;

endmodule

// File: tb/tb_gray_pack_stream.sv
// Directed and randomized checks of gray_pack_stream against a FIFO model and
// hand-computed packed luma words.
module tb_gray_pack_stream;

    logic        bus_clk;
    logic        srst;
    logic [31:0] in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] out_din;
    logic        out_wr_en;
    logic        out_full;
    logic        flush;
    logic [31:0] pixel_count;

    gray_pack_stream dut (
        .bus_clk     (bus_clk),
        .srst        (srst),
        .in_dout     (in_dout),
        .in_empty    (in_empty),
        .in_rd_en    (in_rd_en),
        .out_din     (out_din),
        .out_wr_en   (out_wr_en),
        .out_full    (out_full),
        .flush       (flush),
        .pixel_count (pixel_count)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    bit          s_rd, s_wr, s_empty;
    logic [31:0] s_din;
    int          cyc = 0;
    int          first_rd = -1;
    int          last_wr = -1;
    int          prev_wr = -1;
    int          gap_bad = 0;
    int          rd_low = 0;
    bit          rnd_empty = 0;
    bit          rnd_full = 0;
    bit          full_force = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] luma(input logic [31:0] p);
        int s;
        s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
        return 8'(s >> 8);
    endfunction

    // One clock: sample outputs on the falling edge, then update the FIFO model.
    task automatic cycle();
        @(negedge bus_clk);
        s_rd    = in_rd_en;
        s_wr    = out_wr_en;
        s_din   = out_din;
        s_empty = in_empty;
        if (s_rd && first_rd < 0) first_rd = cyc;
        if (!s_empty && !s_rd) rd_low++;
        if (s_wr) begin
            got_q.push_back(s_din);
            if (prev_wr >= 0 && cyc - prev_wr != 4) gap_bad++;
            prev_wr = cyc;
            last_wr = cyc;
        end
        @(posedge bus_clk);
        #1;
        cyc++;
        if (s_rd && fifo_q.size() > 0) in_dout = fifo_q.pop_front();
        flush    = 1'b0;
        in_empty = (fifo_q.size() == 0) || (rnd_empty && $urandom_range(0, 2) == 0);
        out_full = full_force || (rnd_full && $urandom_range(0, 2) == 0);
    endtask

    task automatic push_pix(input logic [31:0] p);
        fifo_q.push_back(p);
        in_empty = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, 32'(got_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        srst     = 1'b1;
        in_empty = 1'b1;
        fifo_q.delete();
        cycle();
        cycle();
        srst = 1'b0;
        got_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          unstable;
        int          rd_hi;
        logic [31:0] ref_din;
        logic [31:0] w;
        logic [31:0] p;

        srst = 1'b1; in_dout = 32'h0; in_empty = 1'b1; out_full = 1'b0; flush = 1'b0;
        @(posedge bus_clk);
        #1;

        // Reset state
        do_reset();
        chk("reset_in_rd_en", 32'(in_rd_en), 32'd0);
        chk("reset_out_wr_en", 32'(out_wr_en), 32'd0);
        chk("reset_out_din", out_din, 32'h0);
        chk("reset_pixel_count", pixel_count, 32'd0);

        // Primary colours plus mid gray -> one word, 3-cycle latency from last pop
        push_pix(32'h00FF0000); push_pix(32'h0000FF00);
        push_pix(32'h000000FF); push_pix(32'h00808080);
        first_rd = -1;
        run_until(1, 20, "t1_write_count");
        chk("t1_word", got_q[0], 32'h801C954C);
        chk("t1_latency", 32'(last_wr - first_rd), 32'd6);
        cycle();
        chk("t1_pixel_count", pixel_count, 32'd4);

        // 400 white pixels streamed back to back
        do_reset();
        for (int i = 0; i < 400; i++) push_pix(32'h00FFFFFF);
        rd_low = 0; gap_bad = 0; prev_wr = -1;
        run_until(100, 450, "t2_write_count");
        unstable = 0;
        foreach (got_q[i]) if (got_q[i] !== 32'hFFFFFFFF) unstable++;
        chk("t2_bad_words", 32'(unstable), 32'd0);
        chk("t2_rd_gaps", 32'(rd_low), 32'd0);
        chk("t2_write_spacing", 32'(gap_bad), 32'd0);
        cycle();
        chk("t2_pixel_count", pixel_count, 32'd400);

        // Flush of a two-pixel partial word, pops held off while pending
        do_reset();
        push_pix(32'h00FFFFFF); push_pix(32'h00FFFFFF);
        for (int i = 0; i < 5; i++) cycle();
        flush = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) push_pix(32'h00808080);
        #1;
        chk("t3_pending_set", 32'(dut.flush_pending_q), 32'd1);
        chk("t3_rd_held", 32'(in_rd_en), 32'd0);
        run_until(2, 30, "t3_write_count");
        chk("t3_partial_word", got_q[0], 32'h0000FFFF);
        chk("t3_next_word", got_q[1], 32'h80808080);
        chk("t3_pending_clear", 32'(dut.flush_pending_q), 32'd0);
        flush = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("t3_empty_flush_no_write", 32'(got_q.size()), 32'd2);
        chk("t3_pending_clear2", 32'(dut.flush_pending_q), 32'd0);

        // 12 gray pixels, output full for 10 cycles mid-stream
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            p = 32'(i * 32'h00111111);
            push_pix(p);
        end
        for (int i = 0; i < 3; i++) cycle();
        full_force = 1'b1; out_full = 1'b1;
        unstable = 0; rd_hi = 0; ref_din = 32'h0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i >= 4 && s_rd) rd_hi++;
            if (i == 5) ref_din = s_din;
            if (i > 5 && s_din !== ref_din) unstable++;
        end
        full_force = 1'b0; out_full = 1'b0;
        chk("t4_no_write_while_full", 32'(got_q.size()), 32'd0);
        chk("t4_rd_stopped", 32'(rd_hi), 32'd0);
        chk("t4_din_stable", 32'(unstable), 32'd0);
        chk("t4_held_word", ref_din, 32'h44332211);
        run_until(3, 30, "t4_write_count");
        chk("t4_word0", got_q[0], 32'h44332211);
        chk("t4_word1", got_q[1], 32'h88776655);
        chk("t4_word2", got_q[2], 32'hCCBBAA99);

        // Reset in the middle of a word discards it
        do_reset();
        push_pix(32'h00FFFFFF); push_pix(32'h00FFFFFF);
        for (int i = 0; i < 4; i++) cycle();
        srst = 1'b1;
        cycle();
        srst = 1'b0;
        got_q.delete();
        chk("t5_count_after_reset", pixel_count, 32'd0);
        cycle();
        chk("t5_no_write_after_reset", 32'(s_wr), 32'd0);
        for (int i = 0; i < 4; i++) push_pix(32'h00808080);
        run_until(1, 20, "t5_write_count");
        for (int i = 0; i < 5; i++) cycle();
        chk("t5_single_write", 32'(got_q.size()), 32'd1);
        chk("t5_word", got_q[0], 32'h80808080);
        chk("t5_pixel_count", pixel_count, 32'd4);

        // Random pixels with random empty/full against the packing model
        do_reset();
        exp_q.delete();
        w = 32'h0;
        for (int i = 0; i < 200; i++) begin
            p = $urandom();
            push_pix(p);
            w[(i % 4) * 8 +: 8] = luma(p);
            if (i % 4 == 3) exp_q.push_back(w);
        end
        rnd_empty = 1; rnd_full = 1;
        run_until(50, 3000, "t6_write_count");
        rnd_empty = 0; rnd_full = 0; out_full = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("t6_no_extra_writes", 32'(got_q.size()), 32'd50);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("t6_word%0d", i), got_q[i], exp_q[i]);
        chk("t6_pixel_count", pixel_count, 32'd200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
